fifo_drain_ctrl: RTL and testbench

Read-side controller for a queue: pops words from the queue storage, driven by the queue occupancy count, and streams them to a downstream port with a valid/ready handshake.
Drains in bursts of at most MAX_BURST words and tags the final word of each burst with out_last.
Sits in QUEUE_TOP beside the occupancy counter: its rd_en is the counter's rd_en, and the counter's index feeds it.
Queue storage has 1-cycle synchronous read latency.

---
 rtl/fifo_drain_pkg.sv | 18 +
 rtl/fifo_drain_ctrl_if.sv | 24 ++
 rtl/fifo_drain_obuf.sv | 75 +++++++
 rtl/fifo_drain_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the queue drain controller.
// Holds the FSM state encoding, the output-buffer depth and the index-width helper.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    localparam int OB_DEPTH = 2;

    // Occupancy must represent both 0 and FIFO_SIZE, hence the extra bit.
    function automatic int index_width(input int fifo_size);
        return $clog2(fifo_size) + 1;
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Downstream valid/ready word stream leaving the drain controller.
// The master drives words; the slave returns the accept strobe.
interface fifo_drain_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_drain_obuf.sv
// Two-entry circular buffer of {last, data} words between storage read and downstream port.
// Entries reset to zero so the head presents zero data while empty after reset.
module fifo_drain_obuf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_head_last,
    output logic [1:0]        o_count
);

    localparam int PTR_W = $clog2(OB_DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] w_ent_data [OB_DEPTH];
    logic              w_ent_last [OB_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < OB_DEPTH; gi++) begin : g_ent
            logic [DATA_W-1:0] r_data;
            logic              r_last;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_last <= 1'b0;
                end else if (i_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_data <= i_push_data;
                    r_last <= i_push_last;
                end
            end

            assign w_ent_data[gi] = r_data;
            assign w_ent_last[gi] = r_last;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head_data = w_ent_data[r_rd_ptr];
    assign o_head_last = w_ent_last[r_rd_ptr];
    assign o_count     = r_count;

    // Issue throttling guarantees a free slot for every read in flight.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && (r_count == 2'(OB_DEPTH))));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && (r_count == 2'd0)));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side queue controller: pops words in bursts of up to MAX_BURST and streams them
// downstream, tagging the final word of each burst and pulsing burst_done once it is accepted.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int FIFO_SIZE = 64,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_drain_en,
    input  logic [index_width(FIFO_SIZE)-1:0]   i_index,
    output logic                                o_rd_en,
    input  logic [DATA_W-1:0]                   i_rd_data,
    fifo_drain_ctrl_if.master                   dn,
    output logic                                o_busy,
    output logic                                o_burst_done
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    drain_state_t     r_state;
    drain_state_t     w_state_next;
    logic [BC_W-1:0]  r_burst_cnt;
    logic             r_pend;
    logic             r_pend_last;
    logic             r_last_issued;
    logic             r_burst_done;

    logic [1:0]       w_ob_cnt;
    logic [2:0]       w_ob_proj;
    logic             w_pop;
    logic             w_valid;
    logic             w_head_last;
    logic             w_rd_en;
    logic             w_tag;
    logic             w_idx_nz;

    assign w_valid  = (w_ob_cnt != 2'd0);
    assign w_pop    = w_valid & dn.out_ready;
    assign w_idx_nz = (i_index != '0);

    // Buffer occupancy once this cycle's capture and accept have settled.
    assign w_ob_proj = {1'b0, w_ob_cnt} + 3'(r_pend) - 3'(w_pop);

    assign w_rd_en = (r_state == BURST) && w_idx_nz && !r_last_issued && (w_ob_proj < 3'd2);
    assign w_tag   = (r_burst_cnt == BC_W'(MAX_BURST - 1)) || (i_index == 1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_drain_en && w_idx_nz) begin
                    w_state_next = BURST;
                end
            end
            BURST: begin
                if (w_rd_en && w_tag) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Leave as the tagged word is accepted so busy drops with the done pulse.
                if (w_ob_proj == 3'd0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_burst_cnt   <= '0;
            r_pend        <= 1'b0;
            r_pend_last   <= 1'b0;
            r_last_issued <= 1'b0;
            r_burst_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend       <= w_rd_en;
            r_pend_last  <= w_rd_en & w_tag;
            r_burst_done <= (r_state == FLUSH) && (w_state_next == IDLE);

            if (r_state == IDLE) begin
                r_burst_cnt <= '0;
            end else if (w_rd_en) begin
                r_burst_cnt <= r_burst_cnt + BC_W'(1);
            end

            if (w_state_next == IDLE) begin
                r_last_issued <= 1'b0;
            end else if (w_rd_en && w_tag) begin
                r_last_issued <= 1'b1;
            end
        end
    end

    fifo_drain_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_pend),
        .i_push_data (i_rd_data),
        .i_push_last (r_pend_last),
        .i_pop       (w_pop),
        .o_head_data (dn.out_data),
        .o_head_last (w_head_last),
        .o_count     (w_ob_cnt)
    );

    assign dn.out_valid = w_valid;
    assign dn.out_last  = w_head_last & w_valid;
    assign o_rd_en      = w_rd_en;
    assign o_busy       = (r_state != IDLE);
    assign o_burst_done = r_burst_done;

    // This block is the only reader, so the queue cannot run dry before the tagged read.
    a_index_live : assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == BURST) && !r_last_issued) |-> w_idx_nz);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: queue storage/occupancy model, scoreboard of expected words,
// a table of burst vectors plus hand-written latency, stall, flush and reset sequences.
module tb_fifo_drain_ctrl;
    import fifo_drain_pkg::*;

    localparam int FIFO_SIZE = 64;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;
    localparam int IDX_W     = 7;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    typedef struct {
        int add_words;
        int ready_mode;
        int exp_rd;
        int exp_index;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              drain_en = 1'b0;
    logic              rd_en;
    logic              busy;
    logic              burst_done;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;

    logic [DATA_W-1:0] mem [FIFO_SIZE];
    logic [5:0]        m_wr_ptr = '0;
    logic [5:0]        m_rd_ptr = '0;
    logic [IDX_W-1:0]  q_index = '0;
    logic [DATA_W-1:0] q_rd_data = '0;

    fifo_drain_ctrl_if #(.DATA_W(DATA_W)) bus ();

    fifo_drain_ctrl #(
        .FIFO_SIZE (FIFO_SIZE),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_drain_en   (drain_en),
        .i_index      (q_index),
        .o_rd_en      (rd_en),
        .i_rd_data    (q_rd_data),
        .dn           (bus),
        .o_busy       (busy),
        .o_burst_done (burst_done)
    );

    always #5 clk = ~clk;

    // Queue storage with 1-cycle read latency and the occupancy counter beside it.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[m_wr_ptr] <= wr_data;
            m_wr_ptr      <= m_wr_ptr + 6'd1;
        end
        if (rd_en) begin
            q_rd_data <= mem[m_rd_ptr];
            m_rd_ptr  <= m_rd_ptr + 6'd1;
        end
        q_index <= q_index + IDX_W'(wr_en) - IDX_W'(rd_en);
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   rd_cnt = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    exp_t sb [$];
    logic [DATA_W-1:0] stored [$];
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic prev_stall = 1'b0;
    logic s_rd_en, s_valid, s_last, s_done, s_busy;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        exp_t e;
        s_rd_en = rd_en;
        s_valid = bus.out_valid;
        s_last  = bus.out_last;
        s_done  = burst_done;
        s_busy  = busy;
        if (rst_n) begin
            if (rd_en) rd_cnt++;
            if (burst_done) done_cnt++;
            if (bus.out_valid && prev_stall) begin
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", bus.out_data, e.data);
                    chk("sb_last", bus.out_last, e.last);
                end
                acc_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            stored.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic push_expected();
        int   len;
        exp_t e;
        len = (int'(q_index) > MAX_BURST) ? MAX_BURST : int'(q_index);
        for (int i = 0; i < len; i++) begin
            e.data = stored.pop_front();
            e.last = (i == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic clear_counts();
        rd_cnt   = 0;
        acc_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic start_burst();
        clear_counts();
        push_expected();
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [6:0] exp_rd_bits, exp_valid_bits, exp_last_bits, exp_done_bits, exp_busy_bits;
        int k;
        int keep;
        exp_t e;

        vecs[0] = '{add_words: 0,  ready_mode: 1, exp_rd: 8,  exp_index: 0};
        vecs[1] = '{add_words: 3,  ready_mode: 0, exp_rd: 3,  exp_index: 0};
        vecs[2] = '{add_words: 10, ready_mode: 1, exp_rd: 10, exp_index: 0};
        vecs[3] = '{add_words: 20, ready_mode: 0, exp_rd: 16, exp_index: 4};
        vecs[4] = '{add_words: 0,  ready_mode: 1, exp_rd: 4,  exp_index: 0};
        vecs[5] = '{add_words: 16, ready_mode: 1, exp_rd: 16, exp_index: 0};
        vecs[6] = '{add_words: 1,  ready_mode: 0, exp_rd: 1,  exp_index: 0};

        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        rst_n = 1'b1;
        tick();

        // index=3: exact cycle timing of issue, output, last tag and done pulse.
        write_words(3);
        ready_mode     = 0;
        exp_rd_bits    = 7'b0001110;
        exp_valid_bits = 7'b0111000;
        exp_last_bits  = 7'b0100000;
        exp_done_bits  = 7'b1000000;
        exp_busy_bits  = 7'b0111110;
        start_burst();
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("lat_rd_en_c%0d", c), s_rd_en, exp_rd_bits[c]);
            chk($sformatf("lat_valid_c%0d", c), s_valid, exp_valid_bits[c]);
            chk($sformatf("lat_last_c%0d", c), s_last, exp_last_bits[c]);
            chk($sformatf("lat_done_c%0d", c), s_done, exp_done_bits[c]);
            chk($sformatf("lat_busy_c%0d", c), s_busy, exp_busy_bits[c]);
        end
        chk("lat_words", acc_cnt, 3);

        // index=5 with downstream stalled: two reads fill the buffer, then issue stops.
        write_words(5);
        ready_mode = 2;
        bus.out_ready = 1'b0;
        start_burst();
        repeat (8) tick();
        chk("stall_rd_cnt", rd_cnt, 2);
        chk("stall_valid", s_valid, 1);
        chk("stall_accepted", acc_cnt, 0);
        ready_mode = 0;
        wait_done(100);
        chk("stall_words", acc_cnt, 5);
        chk("stall_rd_total", rd_cnt, 5);

        // index=1 with queue writes arriving while the burst flushes.
        write_words(1);
        start_burst();
        tick();
        write_words(3);
        wait_done(100);
        repeat (2) tick();
        chk("one_rd_cnt", rd_cnt, 1);
        chk("one_words", acc_cnt, 1);
        chk("one_done_cnt", done_cnt, 1);
        chk("one_index_after", q_index, 3);

        // index=40 with drain_en held: back-to-back bursts of MAX_BURST.
        write_words(37);
        chk("b40_index_before", q_index, 40);
        clear_counts();
        push_expected();
        drain_en = 1'b1;
        tick();
        wait_done(200);
        chk("b40_rd_cnt", rd_cnt, 16);
        chk("b40_words", acc_cnt, 16);
        chk("b40_index_mid", q_index, 24);
        chk("b40_busy_at_done", s_busy, 0);
        push_expected();
        clear_counts();
        drain_en = 1'b0;
        tick();
        chk("b40_restart_rd_en", s_rd_en, 1);
        chk("b40_restart_busy", s_busy, 1);
        wait_done(200);
        chk("b40_rd_cnt2", rd_cnt, 16);
        chk("b40_index_end", q_index, 8);

        // Table of bursts under different occupancies and downstream patterns.
        for (int v = 0; v < 7; v++) begin
            write_words(vecs[v].add_words);
            ready_mode = vecs[v].ready_mode;
            start_burst();
            wait_done(300);
            repeat (2) tick();
            $display("vector %0d: add=%0d mode=%0d rd=%0d words=%0d done=%0d index=%0d",
                     v, vecs[v].add_words, vecs[v].ready_mode, rd_cnt, acc_cnt, done_cnt, q_index);
            chk($sformatf("vec%0d_rd_cnt", v), rd_cnt, vecs[v].exp_rd);
            chk($sformatf("vec%0d_words", v), acc_cnt, vecs[v].exp_rd);
            chk($sformatf("vec%0d_done_once", v), done_cnt, 1);
            chk($sformatf("vec%0d_index", v), q_index, vecs[v].exp_index);
            chk($sformatf("vec%0d_idle", v), s_busy, 0);
            chk($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
        end

        // Reset after 4 of 12 words: outputs drop at once, in-flight words are lost.
        ready_mode = 0;
        write_words(12);
        start_burst();
        k = 0;
        while (acc_cnt < 4 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_mid_reached", acc_cnt, 4);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", rd_en, 0);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        keep = int'(q_index);
        while (sb.size() > keep) void'(sb.pop_front());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            stored.push_back(e.data);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("post_rst_valid_c%0d", c), s_valid, 0);
            chk($sformatf("post_rst_busy_c%0d", c), s_busy, 0);
            chk($sformatf("post_rst_rd_en_c%0d", c), s_rd_en, 0);
        end
        start_burst();
        wait_done(200);
        chk("post_rst_words", acc_cnt, keep);
        chk("post_rst_index", q_index, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
